rsa_key_setup: RTL and testbench

//  Key-preparation stage upstream of the RSA encrypt/decrypt controller.

---
 rtl/rsa_pkg.sv | 47 ++++
 rtl/rsa_muldiv.sv | 139 +++++++++++++
 rtl/rsa_key_setup.sv | 227 ++++++++++++++++++++++
 tb/tb_rsa_key_setup.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and helpers for the RSA key-preparation block.
//  - state_e  : key-setup FSM states
//  - md_op_e  : operation codes for the shared multiply/divide engine
//  - DEF_W/DEF_W2/DEF_WS : default operand width W, 2W and 2W+1
//  - ws_add/ws_sub : two's complement add/sub on the signed Euclid
//    coefficients. They work at MAX_WS bits; callers cast the result
//    back to their own 2W+1 width, which gives arithmetic mod 2^(2W+1).
package rsa_pkg;

    localparam int DEF_W  = 1024;
    localparam int DEF_W2 = 2 * DEF_W;
    localparam int DEF_WS = DEF_W2 + 1;

    // Widest W the helper functions support.
    localparam int MAX_W  = 2048;
    localparam int MAX_WS = 2 * MAX_W + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MUL,
        S_CHK,
        S_DIV,
        S_MULQ,
        S_UPD,
        S_FIX,
        S_VERIFY,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MD_MULN,    // dual-lane multiply over W multiplier bits (n and phi)
        MD_MULQ,    // single-lane multiply over 2W multiplier bits (qt*t1)
        MD_DIV,     // restoring divide, 2W quotient bits
        MD_MODMUL   // (x*y) mod m, MSB-first, two cycles per bit of y
    } md_op_e;

    function automatic logic [MAX_WS-1:0] ws_add(input logic [MAX_WS-1:0] a,
                                                 input logic [MAX_WS-1:0] b);
        return a + b;
    endfunction

    function automatic logic [MAX_WS-1:0] ws_sub(input logic [MAX_WS-1:0] a,
                                                 input logic [MAX_WS-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/rsa_muldiv.sv
// rsa_muldiv: sequential shift-add multiplier / restoring divider shared by
// every arithmetic phase of the key setup.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  i_go            load operands and start i_op (only issued while idle)
//  i_op            md_op_e operation code
//  i_x0, i_y0      lane-0 multiplicand / multiplier; i_y0 is the dividend
//                  for MD_DIV and the MSB-first multiplier for MD_MODMUL
//  i_x1, i_y1      lane-1 multiplicand / multiplier (MD_MULN only)
//  i_m             divisor (MD_DIV) or modulus (MD_MODMUL)
//  o_done          one-cycle pulse; results hold until the next i_go
//  o_r0            lane-0 product (mod 2^(2W+1)), quotient, or modmul result
//  o_r1            lane-1 product or remainder
module rsa_muldiv
    import rsa_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_go,
    input  logic [1:0]        i_op,
    input  logic [2*W:0]      i_x0,
    input  logic [2*W-1:0]    i_y0,
    input  logic [2*W-1:0]    i_x1,
    input  logic [2*W-1:0]    i_y1,
    input  logic [2*W-1:0]    i_m,
    output logic              o_done,
    output logic [2*W:0]      o_r0,
    output logic [2*W-1:0]    o_r1
);

    localparam int W2 = 2 * W;
    localparam int WS = W2 + 1;
    localparam int CW = $clog2(2 * W2 + 1);

    md_op_e          r_op;
    logic            r_run;
    logic            r_done;
    logic            r_ph;
    logic [CW-1:0]   r_cnt;
    logic [WS-1:0]   r_acc0, r_x0;
    logic [W2-1:0]   r_acc1, r_x1;
    logic [W2-1:0]   r_y0, r_y1, r_m;

    logic [CW-1:0]   w_steps;
    logic [WS-1:0]   w_cand;
    logic [WS-1:0]   w_red;
    logic            w_ge;

    always_comb begin
        w_steps = CW'(2 * W2);
        case (i_op)
            MD_MULN: w_steps = CW'(W);
            MD_MULQ: w_steps = CW'(W2);
            MD_DIV:  w_steps = CW'(W2);
            default: w_steps = CW'(2 * W2);
        endcase
    end

    // One compare/subtract against m serves both the divider and the
    // modular multiplier. In MD_MODMUL phase 0 doubles the accumulator,
    // phase 1 adds x when the current multiplier bit is set; each is
    // followed by a single conditional subtract since operands stay < m.
    always_comb begin
        w_cand = '0;
        case (r_op)
            MD_DIV:    w_cand = {r_acc1, r_y0[W2-1]};
            MD_MODMUL: w_cand = r_ph ? (r_acc0 + (r_y0[W2-1] ? r_x0 : '0))
                                     : {r_acc0[WS-2:0], 1'b0};
            default:   w_cand = '0;
        endcase
        w_ge  = (w_cand >= {1'b0, r_m});
        w_red = w_ge ? (w_cand - {1'b0, r_m}) : w_cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= MD_MULN;
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_ph   <= 1'b0;
            r_cnt  <= '0;
            r_acc0 <= '0;
            r_acc1 <= '0;
            r_x0   <= '0;
            r_x1   <= '0;
            r_y0   <= '0;
            r_y1   <= '0;
            r_m    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_go) begin
                r_op   <= md_op_e'(i_op);
                r_run  <= 1'b1;
                r_ph   <= 1'b0;
                r_cnt  <= w_steps;
                r_acc0 <= '0;
                r_acc1 <= '0;
                r_x0   <= i_x0;
                r_x1   <= i_x1;
                r_y0   <= i_y0;
                r_y1   <= i_y1;
                r_m    <= i_m;
            end else if (r_run) begin
                case (r_op)
                    MD_DIV: begin
                        r_acc1 <= w_red[W2-1:0];
                        r_acc0 <= {r_acc0[WS-2:0], w_ge};
                        r_y0   <= r_y0 << 1;
                    end
                    MD_MODMUL: begin
                        r_acc0 <= w_red;
                        r_ph   <= ~r_ph;
                        if (r_ph) r_y0 <= r_y0 << 1;
                    end
                    default: begin
                        if (r_y0[0]) r_acc0 <= r_acc0 + r_x0;
                        if (r_y1[0]) r_acc1 <= r_acc1 + r_x1;
                        r_x0 <= r_x0 << 1;
                        r_x1 <= r_x1 << 1;
                        r_y0 <= r_y0 >> 1;
                        r_y1 <= r_y1 >> 1;
                    end
                endcase
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_r0   = r_acc0;
    assign o_r1   = r_acc1;

endmodule

// File: rtl/rsa_key_setup.sv
// rsa_key_setup: from primes p, q and public exponent e computes
// n = p*q, phi = (p-1)*(q-1) and d = e^-1 mod phi with an iterative
// extended Euclid running on the shared rsa_muldiv engine.
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  start       1-cycle request, sampled only while idle
//  p, q, e     W-bit operands captured on an accepted start
//  busy        high from the cycle after an accepted start until results
//  valid/err   result status, held until the next accepted start
//  n, phi, d   2W-bit results, updated only when the run completes
// Build option: define RSA_KEY_SELFCHECK_EN to add a VERIFY state that
// recomputes (e*d) mod phi and flags err if it is not 1.
module rsa_key_setup
    import rsa_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     p,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     e,
    output logic             busy,
    output logic             valid,
    output logic             err,
    output logic [2*W-1:0]   n,
    output logic [2*W-1:0]   phi,
    output logic [2*W-1:0]   d
);

    localparam int W2 = 2 * W;
    localparam int WS = W2 + 1;

    state_e          r_state, w_next;
    logic [W-1:0]    r_e;
    logic [W2-1:0]   r_nt, r_phit, r_dt;
    logic            r_errt;
    logic [W2-1:0]   r_r0, r_r1, r_rm;
    logic [WS-1:0]   r_t0, r_t1;          // signed Euclid coefficients
    logic [W2-1:0]   r_n, r_phi, r_d;
    logic            r_valid, r_err;

    logic            w_go;
    md_op_e          w_op;
    logic [WS-1:0]   w_x0;
    logic [W2-1:0]   w_y0, w_x1, w_y1, w_m;
    logic            w_md_done;
    logic [WS-1:0]   w_md_r0;
    logic [W2-1:0]   w_md_r1;

    logic            w_bad;
    logic [WS-1:0]   w_t1n;
    logic [W2-1:0]   w_dfix;

    rsa_muldiv #(.W(W)) u_md (
        .clk    (clk),
        .rst    (rst),
        .i_go   (w_go),
        .i_op   (w_op),
        .i_x0   (w_x0),
        .i_y0   (w_y0),
        .i_x1   (w_x1),
        .i_y1   (w_y1),
        .i_m    (w_m),
        .o_done (w_md_done),
        .o_r0   (w_md_r0),
        .o_r1   (w_md_r1)
    );

    // In CHK the engine still holds n (r0) and phi (r1) from MUL.
    assign w_bad = (w_md_r1 == '0) || (r_e < W'(2)) || (W2'(r_e) >= w_md_r1);
    // t0 - qt*t1; the product is exact because |qt*t1| <= phi.
    assign w_t1n = WS'(ws_sub(MAX_WS'(r_t0), MAX_WS'(w_md_r0)));
    // A negative coefficient is brought into (0, phi) by one add.
    assign w_dfix = r_t0[WS-1] ? W2'(ws_add(MAX_WS'(r_t0), MAX_WS'(r_phit)))
                               : r_t0[W2-1:0];

    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        w_op   = MD_MULN;
        w_x0   = '0;
        w_y0   = '0;
        w_x1   = '0;
        w_y1   = '0;
        w_m    = '0;
        case (r_state)
            S_IDLE: if (start) begin
                w_go   = 1'b1;
                w_op   = MD_MULN;
                w_x0   = WS'(p);
                w_y0   = W2'(q);
                w_x1   = W2'(p - W'(1));
                w_y1   = W2'(q - W'(1));
                w_next = S_MUL;
            end
            S_MUL: if (w_md_done) w_next = S_CHK;
            S_CHK: begin
                if (w_bad) begin
                    w_next = S_DONE;
                end else begin
                    w_go   = 1'b1;
                    w_op   = MD_DIV;
                    w_y0   = w_md_r1;
                    w_m    = W2'(r_e);
                    w_next = S_DIV;
                end
            end
            S_DIV: if (w_md_done) begin
                w_go   = 1'b1;
                w_op   = MD_MULQ;
                w_x0   = r_t1;
                w_y0   = w_md_r0[W2-1:0];
                w_next = S_MULQ;
            end
            S_MULQ: if (w_md_done) w_next = S_UPD;
            S_UPD: begin
                if (r_rm != '0) begin
                    w_go   = 1'b1;
                    w_op   = MD_DIV;
                    w_y0   = r_r1;
                    w_m    = r_rm;
                    w_next = S_DIV;
                end else begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
`ifdef RSA_KEY_SELFCHECK_EN
                if (r_r0 == W2'(1)) begin
                    w_go   = 1'b1;
                    w_op   = MD_MODMUL;
                    w_x0   = WS'(r_e);
                    w_y0   = w_dfix;
                    w_m    = r_phit;
                    w_next = S_VERIFY;
                end
`endif
            end
`ifdef RSA_KEY_SELFCHECK_EN
            S_VERIFY: if (w_md_done) w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_e     <= '0;
            r_nt    <= '0;
            r_phit  <= '0;
            r_dt    <= '0;
            r_errt  <= 1'b0;
            r_r0    <= '0;
            r_r1    <= '0;
            r_rm    <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_n     <= '0;
            r_phi   <= '0;
            r_d     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_e     <= e;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
                S_CHK: begin
                    r_nt   <= w_md_r0[W2-1:0];
                    r_phit <= w_md_r1;
                    r_errt <= w_bad;
                    r_dt   <= '0;
                    r_r0   <= w_md_r1;
                    r_r1   <= W2'(r_e);
                    r_t0   <= '0;
                    r_t1   <= WS'(1);
                end
                S_DIV: if (w_md_done) r_rm <= w_md_r1;
                S_UPD: begin
                    r_r0 <= r_r1;
                    r_r1 <= r_rm;
                    r_t0 <= r_t1;
                    r_t1 <= w_t1n;
                end
                S_FIX: begin
                    // r0 now holds gcd(e, phi); no inverse unless it is 1.
                    if (r_r0 != W2'(1)) begin
                        r_errt <= 1'b1;
                        r_dt   <= '0;
                    end else begin
                        r_dt <= w_dfix;
                    end
                end
`ifdef RSA_KEY_SELFCHECK_EN
                S_VERIFY: if (w_md_done && (w_md_r0 != WS'(1))) begin
                    r_errt <= 1'b1;
                    r_dt   <= '0;
                end
`endif
                S_DONE: begin
                    r_n     <= r_nt;
                    r_phi   <= r_phit;
                    r_d     <= r_errt ? '0 : r_dt;
                    r_valid <= ~r_errt;
                    r_err   <= r_errt;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign valid = r_valid;
    assign err   = r_err;
    assign n     = r_n;
    assign phi   = r_phi;
    assign d     = r_d;

endmodule

// File: tb/tb_rsa_key_setup.sv
module tb_rsa_key_setup;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          start16 = 1'b0;
    logic [15:0]   p16 = '0, q16 = '0, e16 = '0;
    logic          busy16, valid16, err16;
    logic [31:0]   n16, phi16, d16;

    logic          start64 = 1'b0;
    logic [63:0]   p64 = '0, q64 = '0, e64 = '0;
    logic          busy64, valid64, err64;
    logic [127:0]  n64, phi64, d64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rsa_key_setup #(.W(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .p(p16), .q(q16), .e(e16),
        .busy(busy16), .valid(valid16), .err(err16),
        .n(n16), .phi(phi16), .d(d16)
    );

    rsa_key_setup #(.W(64)) u64 (
        .clk(clk), .rst(rst), .start(start64), .p(p64), .q(q64), .e(e64),
        .busy(busy64), .valid(valid64), .err(err64),
        .n(n64), .phi(phi64), .d(d64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start16_pulse(input logic [15:0] pp, input logic [15:0] qq, input logic [15:0] ee);
        @(negedge clk);
        p16 = pp; q16 = qq; e16 = ee; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait16(input string tag);
        for (int i = 0; i < 6000; i++) begin
            if (!busy16) break;
            @(negedge clk);
        end
        chk(tag, 128'(busy16), 128'(0));
    endtask

    task automatic expect16(input string tag, input logic v, input logic er,
                            input logic [31:0] en, input logic [31:0] ep, input logic [31:0] ed);
        chk({tag, "_valid"}, 128'(valid16), 128'(v));
        chk({tag, "_err"},   128'(err16),   128'(er));
        chk({tag, "_n"},     128'(n16),     128'(en));
        chk({tag, "_phi"},   128'(phi16),   128'(ep));
        chk({tag, "_d"},     128'(d16),     128'(ed));
    endtask

    // Textbook extended Euclid on wide signed integers.
    function automatic logic [127:0] modinv(input logic [127:0] a, input logic [127:0] m, output bit ok);
        logic signed [131:0] r0, r1, t0, t1, qq, tmp;
        r0 = 132'(m); r1 = 132'(a); t0 = 0; t1 = 1;
        for (int k = 0; k < 400; k++) begin
            if (r1 == 0) break;
            qq  = r0 / r1;
            tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
            tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
        end
        ok = (r0 == 1);
        if (t0 < 0) t0 = t0 + 132'(m);
        return ok ? t0[127:0] : 128'd0;
    endfunction

    initial begin
        logic [127:0] pbig, nexp, phiexp, dexp;
        logic [255:0] prod, modv;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy16), 128'(0));
        chk("rst_valid", 128'(valid16), 128'(0));
        chk("rst_err", 128'(err16), 128'(0));
        chk("rst_n", 128'(n16), 128'(0));
        chk("rst_d", 128'(d16), 128'(0));
        rst = 1'b0;

        // 1: textbook key
        start16_pulse(16'd61, 16'd53, 16'd17);
        chk("s1_busy", 128'(busy16), 128'(1));
        wait16("s1_timeout");
        expect16("s1", 1'b1, 1'b0, 32'd3233, 32'd3120, 32'd2753);

        // 2: e shares factor 3 with phi
        start16_pulse(16'd61, 16'd53, 16'd3);
        chk("s2_valid_cleared", 128'(valid16), 128'(0));
        wait16("s2_timeout");
        expect16("s2", 1'b0, 1'b1, 32'd3233, 32'd3120, 32'd0);

        // 3a: p=1 gives phi=0
        start16_pulse(16'd1, 16'd53, 16'd17);
        wait16("s3a_timeout");
        expect16("s3a", 1'b0, 1'b1, 32'd53, 32'd0, 32'd0);

        // 3b: e=1
        start16_pulse(16'd61, 16'd53, 16'd1);
        wait16("s3b_timeout");
        expect16("s3b", 1'b0, 1'b1, 32'd3233, 32'd3120, 32'd0);

        // 4: second start while busy is ignored
        start16_pulse(16'd61, 16'd53, 16'd17);
        repeat (4) @(negedge clk);
        chk("s4_busy_a", 128'(busy16), 128'(1));
        chk("s4_err_cleared", 128'(err16), 128'(0));
        start16_pulse(16'd7, 16'd11, 16'd7);
        chk("s4_busy_b", 128'(busy16), 128'(1));
        repeat (40) @(negedge clk);
        chk("s4_busy_c", 128'(busy16), 128'(1));
        chk("s4_n_stable", 128'(n16), 128'(32'd3233));
        wait16("s4_timeout");
        expect16("s4", 1'b1, 1'b0, 32'd3233, 32'd3120, 32'd2753);

        // 5: reset in the middle of the first divide
        start16_pulse(16'd61, 16'd53, 16'd17);
        repeat (25) @(negedge clk);
        chk("s5_busy_pre", 128'(busy16), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s5_rst_busy", 128'(busy16), 128'(0));
        expect16("s5_rst", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        start16_pulse(16'd61, 16'd53, 16'd17);
        wait16("s5_timeout");
        expect16("s5", 1'b1, 1'b0, 32'd3233, 32'd3120, 32'd2753);

        // 6: W=64 with a random odd e coprime to phi
        pbig = 128'd1180591620717411303449;
        p64  = pbig[63:0];
        q64  = 64'hFFFF_FFFF_FFFF_FFC5;
        nexp   = 128'(p64) * 128'(q64);
        phiexp = 128'(p64 - 64'd1) * 128'(q64 - 64'd1);
        ok = 1'b0;
        dexp = '0;
        for (int k = 0; k < 64; k++) begin
            e64 = {$urandom, $urandom} | 64'd1;
            if (e64 < 64'd3) e64 = 64'd65537;
            dexp = modinv(128'(e64), phiexp, ok);
            if (ok) break;
        end
        @(negedge clk);
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            if (!busy64) break;
            @(negedge clk);
        end
        chk("s6_timeout", 128'(busy64), 128'(0));
        chk("s6_n", n64, nexp);
        chk("s6_phi", phi64, phiexp);
        chk("s6_d", d64, dexp);
        chk("s6_err", 128'(err64), 128'(!ok));
        chk("s6_valid", 128'(valid64), 128'(ok));
        if (ok) begin
            prod = 256'(128'(e64)) * 256'(d64);
            modv = prod % 256'(phiexp);
            chk("s6_ed_mod_phi", modv[127:0], 128'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
